// File: rtl/mem_port_seq.sv
// Purpose: sequences one shared memory port between instruction fetch and load/store data access.
// Latency: non-memory instr 2 cycles, load/store 4 cycles (zero wait), +1 per memory wait cycle.
// Backpressure: PC held until i_mem_ack (or timeout); request fields stay stable while o_mem_req=1.
// Optional build macro MEM_PORT_SEQ_PERF_EN adds o_instr_cnt / o_stall_cnt performance counters.
module mem_port_seq #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ADDR_W-1:0]   i_pc,
    output logic                o_pc_en,
    output logic [DATA_W-1:0]   o_instr,
    output logic                o_instr_vld,
    input  logic                i_lsu_req,
    input  logic                i_lsu_we,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_bmask,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_lsu_done,
    output logic                o_bus_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata
`ifdef MEM_PORT_SEQ_PERF_EN
    ,
    output logic [31:0]         o_instr_cnt,
    output logic [31:0]         o_stall_cnt
`endif
);

    localparam int BM_W = DATA_W / 8;
    // Last wait count before the timeout fires: the request is then live for TIMEOUT_CYC cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [15:0]         wait_q;
    logic                lsu_we_q;
    logic [ADDR_W-1:0]   lsu_addr_q;
    logic [DATA_W-1:0]   lsu_wdata_q;
    logic [BM_W-1:0]     lsu_bmask_q;
    logic [DATA_W-1:0]   instr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                mem_busy;
    logic                timeout_hit;

    assign mem_busy    = (state_q == S_FETCH) || (state_q == S_DATA);
    // A same-cycle ack always takes priority over the timeout.
    assign timeout_hit = mem_busy && !i_mem_ack && (wait_q == TO_LAST);

    // Sequencer: state, wait counter, latched instruction/load data, registered LSU request fields.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            lsu_we_q    <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
            lsu_bmask_q <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            // Counter restarts on every state entry; only a waiting request keeps it running.
            wait_q <= '0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_mem_ack) begin
                        instr_q <= i_mem_rdata;
                        state_q <= S_EXEC;
                    end else if (timeout_hit) begin
                        instr_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_EXEC;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (i_lsu_req) begin
                        lsu_we_q    <= i_lsu_we;
                        lsu_addr_q  <= i_lsu_addr;
                        lsu_wdata_q <= i_lsu_wdata;
                        lsu_bmask_q <= i_lsu_bmask;
                        state_q     <= S_DATA;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DATA: begin
                    if (i_mem_ack) begin
                        if (!lsu_we_q) begin
                            rdata_q <= i_mem_rdata;
                        end
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        if (!lsu_we_q) begin
                            rdata_q <= '0;
                        end
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Port outputs decoded from the state register; i_pc is safe to pass through since it only moves on o_pc_en.
    always_comb begin
        o_mem_req   = mem_busy;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        o_instr_vld = (state_q == S_EXEC) || (state_q == S_DONE);
        o_lsu_done  = (state_q == S_DONE);
        o_pc_en     = ((state_q == S_EXEC) && !i_lsu_req) || (state_q == S_DONE);
        if (state_q == S_FETCH) begin
            o_mem_addr  = i_pc;
            o_mem_bmask = '1;
        end else if (state_q == S_DATA) begin
            o_mem_we    = lsu_we_q;
            o_mem_addr  = lsu_addr_q;
            o_mem_wdata = lsu_wdata_q;
            o_mem_bmask = lsu_bmask_q;
        end
    end

    assign o_instr     = instr_q;
    assign o_lsu_rdata = rdata_q;
    assign o_bus_err   = err_q;

`ifdef MEM_PORT_SEQ_PERF_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;

    // Retired-instruction and memory-stall counters, free-running with natural wrap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (o_pc_en) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (mem_busy && !i_mem_ack) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_instr_cnt = instr_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_seq.sv
// Bench for mem_port_seq: the bench plays memory and datapath, one instruction at a time.
// Expected timing, data and error state come from per-instruction rules (wait counts, timeout limit).
// Spurious acks are injected whenever no request is outstanding.
module tb_mem_port_seq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b1;
    logic [AW-1:0]  i_pc = '0;
    logic           o_pc_en;
    logic [DW-1:0]  o_instr;
    logic           o_instr_vld;
    logic           i_lsu_req = 1'b0;
    logic           i_lsu_we = 1'b0;
    logic [AW-1:0]  i_lsu_addr = '0;
    logic [DW-1:0]  i_lsu_wdata = '0;
    logic [3:0]     i_lsu_bmask = '0;
    logic [DW-1:0]  o_lsu_rdata;
    logic           o_lsu_done;
    logic           o_bus_err;
    logic           o_mem_req;
    logic           o_mem_we;
    logic [AW-1:0]  o_mem_addr;
    logic [DW-1:0]  o_mem_wdata;
    logic [3:0]     o_mem_bmask;
    logic           i_mem_ack = 1'b0;
    logic [DW-1:0]  i_mem_rdata = '0;
`ifdef MEM_PORT_SEQ_PERF_EN
    logic [31:0]    o_instr_cnt;
    logic [31:0]    o_stall_cnt;
`endif

    mem_port_seq #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pc        (i_pc),
        .o_pc_en     (o_pc_en),
        .o_instr     (o_instr),
        .o_instr_vld (o_instr_vld),
        .i_lsu_req   (i_lsu_req),
        .i_lsu_we    (i_lsu_we),
        .i_lsu_addr  (i_lsu_addr),
        .i_lsu_wdata (i_lsu_wdata),
        .i_lsu_bmask (i_lsu_bmask),
        .o_lsu_rdata (o_lsu_rdata),
        .o_lsu_done  (o_lsu_done),
        .o_bus_err   (o_bus_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
`ifdef MEM_PORT_SEQ_PERF_EN
        ,
        .o_instr_cnt (o_instr_cnt),
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Architectural expectations
    logic [31:0] m_instr = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic [31:0] pc      = '0;
    int          m_icnt  = 0;
    int          m_scnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction from its first FETCH cycle (entered at posedge+1) to the cycle after o_pc_en.
    // fw/dw: memory wait states for fetch/data; negative = never ack (timeout expected).
    task automatic run_instr(input int fw, input int dw, input logic lreq, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] bm, input logic [31:0] iword,
                             input logic [31:0] dword);
        int  phase, rc, cyc, w, freq_n, dreq_n, done_n;
        int  fexp, dexp, cexp;
        bit  fin, dropped;
        fexp = (fw < 0) ? TO : fw + 1;
        dexp = lreq ? ((dw < 0) ? TO : dw + 1) : 0;
        cexp = fexp + 1 + (lreq ? dexp + 1 : 0);
        phase = 0; rc = 0; cyc = 0; freq_n = 0; dreq_n = 0; done_n = 0;
        fin = 0; dropped = 0;
        i_pc = pc;
        i_lsu_req = lreq; i_lsu_we = we; i_lsu_addr = addr;
        i_lsu_wdata = wdata; i_lsu_bmask = bm;
        while (!fin && cyc < 60) begin
            cyc++;
            #1;
            if (dropped) begin
                check("req_drop_after_ack", o_mem_req, 1'b0);
                dropped = 0;
            end
            if (o_pc_en) check("pc_en_without_req", o_mem_req, 1'b0);
            if (o_mem_req) begin
                rc++;
                if (phase == 0) begin
                    check("fetch_addr", o_mem_addr, pc);
                    check("fetch_we", o_mem_we, 1'b0);
                    check("fetch_bmask", o_mem_bmask, 4'hF);
                    w = fw;
                end else begin
                    check("data_addr", o_mem_addr, addr);
                    check("data_we", o_mem_we, we);
                    check("data_wdata", o_mem_wdata, wdata);
                    check("data_bmask", o_mem_bmask, bm);
                    // Fields must come from the EXEC-time snapshot, not the live inputs.
                    if (rc == 1) begin
                        i_lsu_we = ~we; i_lsu_addr = $urandom;
                        i_lsu_wdata = $urandom; i_lsu_bmask = ~bm;
                    end
                    w = dw;
                end
                if (w >= 0 && rc == w + 1) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = (phase == 0) ? iword : dword;
                end else begin
                    i_mem_ack = 1'b0;
                    i_mem_rdata = $urandom;
                    m_scnt++;
                end
                if (i_mem_ack || (w < 0 && rc == TO)) begin
                    if (phase == 0) begin
                        freq_n = rc;
                        m_instr = (w < 0) ? 32'h0 : iword;
                    end else begin
                        dreq_n = rc;
                        if (!we) m_rdata = (w < 0) ? 32'h0 : dword;
                    end
                    if (w < 0) m_err = 1'b1;
                    phase++;
                    rc = 0;
                    dropped = 1;
                end
            end else begin
                i_mem_ack = 1'($urandom_range(0, 1));
                i_mem_rdata = $urandom;
                if (o_instr_vld) check("instr", o_instr, m_instr);
            end
            if (o_lsu_done) done_n++;
            if (o_pc_en) begin
                fin = 1;
                m_icnt++;
                check("pc_en_cycle", cyc, cexp);
                check("done_with_pc_en", o_lsu_done, lreq);
                check("lsu_rdata", o_lsu_rdata, m_rdata);
                check("bus_err", o_bus_err, m_err);
            end
            @(posedge i_clk);
            #1;
        end
        check("pc_en_seen", fin, 1'b1);
        check("fetch_req_cycles", freq_n, fexp);
        check("data_req_cycles", dreq_n, dexp);
        check("lsu_done_pulses", done_n, lreq ? 1 : 0);
        pc = pc + 32'd4;
    endtask

    initial begin
        int r, fw, dw;
        // Reset state
        #12;
        check("rst_mem_req", o_mem_req, 1'b0);
        check("rst_pc_en", o_pc_en, 1'b0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_instr_vld", o_instr_vld, 1'b0);
        check("rst_lsu_rdata", o_lsu_rdata, 32'h0);
        check("rst_lsu_done", o_lsu_done, 1'b0);
        check("rst_bus_err", o_bus_err, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Zero-wait ALU instructions: o_pc_en every 2nd cycle
        run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0013, 32'h0);
        run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0040_0093, 32'h0);
        run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0021_8233, 32'h0);

        // Load with 3 data wait states
        run_instr(0, 3, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h1000_2003, 32'hDEAD_BEEF);
        check("load_rdata_const", o_lsu_rdata, 32'hDEAD_BEEF);

        // Store, partial byte mask: load data register must not change
        run_instr(1, 0, 1'b1, 1'b1, 32'h200, 32'h0000_1234, 4'b0011, 32'h0020_A023, 32'h5555_AAAA);
        check("store_keeps_rdata", o_lsu_rdata, 32'hDEAD_BEEF);
        check("no_err_yet", o_bus_err, 1'b0);

        // Fetch never acked: timeout after TO request cycles, instr forced 0, sticky error
        run_instr(-1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'h0);
        check("timeout_err", o_bus_err, 1'b1);
        check("timeout_instr", o_instr, 32'h0);

        // Data load never acked: rdata forced 0
        run_instr(0, -1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0003_2283, 32'h1111_1111);
        check("data_timeout_rdata", o_lsu_rdata, 32'h0);

        // Randomized instruction mix
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 7);
            fw = (r == 7) ? -1 : r % 4;
            r  = $urandom_range(0, 7);
            dw = (r == 7) ? -1 : r % 4;
            run_instr(fw, dw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                      $urandom, $urandom);
        end
        check("err_sticky", o_bus_err, 1'b1);

        // Reset during a data wait: request drops at once, late ack ignored, restart at FETCH
        i_pc = pc; i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h400;
        #1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hA5A5_0001;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #2;
        check("mid_data_req", o_mem_req, 1'b1);
        check("mid_data_addr", o_mem_addr, 32'h400);
        i_reset = 1'b1;
        #1;
        check("reset_req_drop", o_mem_req, 1'b0);
        check("reset_err_clr", o_bus_err, 1'b0);
        check("reset_instr_clr", o_instr, 32'h0);
        check("reset_vld_clr", o_instr_vld, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        check("late_ack_ignored", o_instr, 32'h0);
        check("late_ack_rdata", o_lsu_rdata, 32'h0);
        m_instr = '0; m_rdata = '0; m_err = 1'b0; pc = '0;
        m_icnt = 0; m_scnt = 0;

        // 10 instructions, 5 stall cycles in total
        for (int k = 0; k < 8; k++) begin
            run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, $urandom, 32'h0);
        end
        run_instr(3, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0033, 32'h0);
        run_instr(2, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_00B3, 32'h0);
        check("post_reset_no_err", o_bus_err, 1'b0);
`ifdef MEM_PORT_SEQ_PERF_EN
        check("perf_instr_cnt", o_instr_cnt, 32'd10);
        check("perf_stall_cnt", o_stall_cnt, 32'd5);
        check("perf_instr_model", o_instr_cnt, m_icnt);
        check("perf_stall_model", o_stall_cnt, m_scnt);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
